// File: rtl/t_counter_pkg.sv
// Shared helpers for t_counter: direction encodings, Gray conversion, load clamp.
// Functions are sized for the widest legal counter; callers slice to their WIDTH.
package t_counter_pkg;

    localparam int   MAX_WIDTH = 16;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One extra bit so that MODULUS == 2**MAX_WIDTH is representable.
    function automatic logic [MAX_WIDTH:0] clamp_load(input logic [MAX_WIDTH:0] value,
                                                      input logic [MAX_WIDTH:0] modulus);
        return (value < modulus) ? value : (modulus - 1'b1);
    endfunction

endpackage

// File: rtl/t_counter_tff_cell.sv
// Single T flip-flop: toggles on the rising edge when t=1, async active-low clear.
// Latency one clock; no flow control.
module tff_cell (
    output logic q,
    input  logic t,
    input  logic clk,
    input  logic clear
);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/t_counter.sv
// Up/down modulo-MODULUS counter on a bank of T-cells; optional gray output (T_COUNTER_GRAY_EN).
// q changes one clock after en/load, tc is combinational, wrap lags one clock; no backpressure.
module t_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef T_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    if ((WIDTH < 2) || (WIDTH > MAX_WIDTH) || (MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_param
        $error("t_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0]   next_q;
    logic [WIDTH-1:0]   t;
    logic [MAX_WIDTH:0] load_full;
    logic               unused_load_hi;
    logic               at_top;
    logic               at_bottom;
    logic               out_of_range;

    assign load_full      = clamp_load((MAX_WIDTH+1)'(load_val), (MAX_WIDTH+1)'(MODULUS));
    assign unused_load_hi = ^load_full[MAX_WIDTH:WIDTH];

    assign at_top       = (q == MAX_Q);
    assign at_bottom    = (q == '0);
    assign out_of_range = ({1'b0, q} >= MOD_X);

    always_comb begin
        next_q = q;
        if (load) begin
            next_q = load_full[WIDTH-1:0];
        end else if (en) begin
            // An illegal state recovers to zero regardless of direction.
            if (out_of_range) begin
                next_q = '0;
            end else if (up_dn == DIR_UP) begin
                next_q = at_top ? '0 : (q + 1'b1);
            end else begin
                next_q = at_bottom ? MAX_Q : (q - 1'b1);
            end
        end
    end

    assign tc = en & ~load & ((up_dn == DIR_UP) ? at_top : at_bottom);

    // Each cell toggles exactly the bits that differ between q and next_q.
    assign t = q ^ next_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        tff_cell u_tff (
            .q     (q[i]),
            .t     (t[i]),
            .clk   (clk),
            .clear (clear)
        );
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

`ifdef T_COUNTER_GRAY_EN
    logic [MAX_WIDTH-1:0] gray_full;
    logic                 unused_gray_hi;

    assign gray_full      = bin2gray(MAX_WIDTH'(next_q));
    assign unused_gray_hi = ^gray_full;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            gray <= '0;
        end else begin
            gray <= gray_full[WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_t_counter.sv
// Bench for t_counter: table vectors with a scoreboard on a MODULUS=10 instance,
// plus hand sequences for async clear and a MODULUS=16 instance (gray when enabled).
module tb_t_counter;

    logic       clk = 1'b0;
    logic       clear;
    logic       en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap;

    logic       en16, up16, load16;
    logic [3:0] load_val16;
    logic [3:0] q16;
    logic       tc16, wrap16;
`ifdef T_COUNTER_GRAY_EN
    logic [3:0] gray;
    logic [3:0] gray16;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    t_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
`ifdef T_COUNTER_GRAY_EN
        ,
        .gray     (gray)
`endif
    );

    t_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk      (clk),
        .clear    (clear),
        .en       (en16),
        .up_dn    (up16),
        .load     (load16),
        .load_val (load_val16),
        .q        (q16),
        .tc       (tc16),
        .wrap     (wrap16)
`ifdef T_COUNTER_GRAY_EN
        ,
        .gray     (gray16)
`endif
    );

    typedef struct {
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] lv;
        logic       etc;
        logic [3:0] eq;
        logic       ew;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] q;
        logic       w;
    } exp_t;

    vec_t vecs[34];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        en       = v.en;
        up_dn    = v.up;
        load     = v.ld;
        load_val = v.lv;
        #1;
        check($sformatf("vec%0d_tc", idx), int'(tc), int'(v.etc));
        e.idx = idx;
        e.q   = v.eq;
        e.w   = v.ew;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("vec%0d_scoreboard_empty", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_q", e.idx), int'(q), int'(e.q));
            check($sformatf("vec%0d_wrap", e.idx), int'(wrap), int'(e.w));
        end
    endtask

    function automatic vec_t mk(input logic e, input logic u, input logic l, input logic [3:0] lv,
                                input logic etc, input logic [3:0] eq, input logic ew);
        vec_t v;
        v.en = e; v.up = u; v.ld = l; v.lv = lv; v.etc = etc; v.eq = eq; v.ew = ew;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] gexp[16];
        logic [3:0] gprev;
        logic [3:0] tmp;

        gexp = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

        // Up count 0..9, wrap on the 9->0 edge
        for (int i = 0; i < 9; i++) vecs[i] = mk(1, 1, 0, 0, 0, 4'(i + 1), 0);
        vecs[9]  = mk(1, 1, 0, 0,  1, 0, 1);
        vecs[10] = mk(1, 1, 0, 0,  0, 1, 0);
        // Load priority and clamp
        vecs[11] = mk(0, 1, 1, 7,  0, 7, 0);
        vecs[12] = mk(1, 1, 1, 3,  0, 3, 0);
        vecs[13] = mk(0, 1, 1, 9,  0, 9, 0);
        vecs[14] = mk(1, 1, 1, 12, 0, 9, 0);
        vecs[15] = mk(0, 0, 1, 15, 0, 9, 0);
        vecs[16] = mk(0, 0, 1, 10, 0, 9, 0);
        // Down wrap 2,1,0,9,8
        vecs[17] = mk(0, 1, 1, 2,  0, 2, 0);
        vecs[18] = mk(1, 0, 0, 0,  0, 1, 0);
        vecs[19] = mk(1, 0, 0, 0,  0, 0, 0);
        vecs[20] = mk(1, 0, 0, 0,  1, 9, 1);
        vecs[21] = mk(1, 0, 0, 0,  0, 8, 0);
        // Hold
        vecs[22] = mk(0, 1, 0, 0,  0, 8, 0);
        vecs[23] = mk(0, 0, 0, 0,  0, 8, 0);
        vecs[24] = mk(0, 1, 0, 0,  0, 8, 0);
        vecs[25] = mk(0, 0, 1, 9,  0, 9, 0);
        vecs[26] = mk(0, 1, 0, 0,  0, 9, 0);
        // Direction toggling from 4
        vecs[27] = mk(0, 1, 1, 4,  0, 4, 0);
        vecs[28] = mk(1, 1, 0, 0,  0, 5, 0);
        vecs[29] = mk(1, 0, 0, 0,  0, 4, 0);
        vecs[30] = mk(1, 1, 0, 0,  0, 5, 0);
        vecs[31] = mk(1, 0, 0, 0,  0, 4, 0);
        vecs[32] = mk(0, 1, 1, 0,  0, 0, 0);
        vecs[33] = mk(1, 1, 0, 0,  0, 1, 0);

        clear = 1'b0; en = 0; up_dn = 1; load = 0; load_val = 0;
        en16 = 0; up16 = 1; load16 = 0; load_val16 = 0;
        #3;
        check("reset_q", int'(q), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_q16", int'(q16), 0);
`ifdef T_COUNTER_GRAY_EN
        check("reset_gray", int'(gray), 0);
`endif
        @(posedge clk);
        #1;
        check("reset_hold_q", int'(q), 0);
        @(negedge clk);
        clear = 1'b1;

        for (int i = 0; i < 34; i++) apply(vecs[i], i);

        // Async clear mid-count at q=5, then held low across an enabled edge
        apply(mk(0, 1, 1, 5, 0, 5, 0), 100);
        @(negedge clk);
        en = 1; up_dn = 1; load = 0;
        #2;
        clear = 1'b0;
        #1;
        check("aclr_q_immediate", int'(q), 0);
        check("aclr_wrap_immediate", int'(wrap), 0);
        @(posedge clk);
        #1;
        check("aclr_hold_q", int'(q), 0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("aclr_release_first_count", int'(q), 1);

        // Async clear kills a pending wrap pulse
        apply(mk(0, 1, 1, 9, 0, 9, 0), 101);
        apply(mk(1, 1, 0, 0, 1, 0, 1), 102);
        #2;
        clear = 1'b0;
        #1;
        check("aclr_wrap_cleared", int'(wrap), 0);
        @(negedge clk);
        clear = 1'b1;
        en = 0;

        // MODULUS=16: full up cycle 0..15 and wrap, gray aligned with q
        gprev = 4'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            en16 = 1; up16 = 1;
            #1;
            check($sformatf("m16_up%0d_tc", i), int'(tc16), (i == 15) ? 1 : 0);
            @(posedge clk);
            #1;
            tmp = 4'((i + 1) % 16);
            check($sformatf("m16_up%0d_q", i), int'(q16), int'(tmp));
            check($sformatf("m16_up%0d_wrap", i), int'(wrap16), (i == 15) ? 1 : 0);
`ifdef T_COUNTER_GRAY_EN
            check($sformatf("m16_up%0d_gray", i), int'(gray16), int'(gexp[tmp]));
            check($sformatf("m16_up%0d_gray_1bit", i), $countones(gray16 ^ gprev), 1);
            gprev = gray16;
`endif
        end
        @(negedge clk);
        up16 = 0;
        #1;
        check("m16_down_tc", int'(tc16), 1);
        @(posedge clk);
        #1;
        check("m16_down_q", int'(q16), 15);
        check("m16_down_wrap", int'(wrap16), 1);
        @(negedge clk);
        en16 = 0;
        #1;
        check("m16_hold_tc", int'(tc16), 0);
        @(posedge clk);
        #1;
        check("m16_hold_wrap", int'(wrap16), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
